// File: rtl/sram_controller.sv
// ----------------------------------------------------------------------------
// sram_controller : 32-bit MEM-stage port on a 16-bit async SRAM | rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      counter, counter_nxt;
  logic               op_write;
  logic [SRAM_AW-2:0] word;
  logic [31:0]        data;
  logic [31:0]        offset;
  logic               last;
  logic               in_phase;
  logic               drive;
  logic [15:0]        dq_out;
  logic               unused_offset;

  assign offset        = address - 32'(BASE_ADDR);
  assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};
  assign last          = (counter == LAST);
  assign in_phase      = (state == ACC_LO) || (state == ACC_HI);
  assign drive         = op_write && in_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      read_data <= '0;
      op_write  <= 1'b0;
      word      <= '0;
      data      <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
      if (state == IDLE && (rd_en || wr_en)) begin
        op_write <= wr_en;
        word     <= offset[SRAM_AW:2];
        data     <= write_data;
      end
      if (!op_write && last) begin
        if (state == ACC_LO) read_data[15:0]  <= SRAM_DQ;
        if (state == ACC_HI) read_data[31:16] <= SRAM_DQ;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    case (state)
      IDLE: begin
        if (rd_en || wr_en) begin
          state_nxt   = ACC_LO;
          counter_nxt = '0;
        end
      end
      ACC_LO: begin
        if (last) begin
          state_nxt   = ACC_HI;
          counter_nxt = '0;
        end else begin
          counter_nxt = CW'(counter + 1'b1);
        end
      end
      ACC_HI: begin
        if (last) begin
          state_nxt   = DONE;
          counter_nxt = '0;
        end else begin
          counter_nxt = CW'(counter + 1'b1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ready     = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);
  assign SRAM_ADDR = {word, (state == ACC_HI)};
  assign dq_out    = (state == ACC_HI) ? data[31:16] : data[15:0];
  // Releasing WE_N one cycle before the phase ends gives the SRAM data hold time.
  assign SRAM_WE_N = !(drive && ((WAIT_CYCLES == 1) || !last));
  assign SRAM_DQ   = drive ? dq_out : 16'hzzzz;

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// ----------------------------------------------------------------------------
// tb_sram_controller : scoreboard bench, WAIT_CYCLES=1 and =3 instances | rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_sram_controller;

  localparam int BASE  = 1024;
  localparam int AW    = 18;
  localparam int WMASK = (1 << (AW - 1)) - 1;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [1:0]    wr_en, rd_en, ready, we_n, sram_oe, busy, cur_wr;
  logic [31:0]   address [2];
  logic [31:0]   write_data [2];
  logic [31:0]   read_data [2];
  logic [31:0]   last_rd [2];
  logic [AW-1:0] sram_addr [2];
  wire  [15:0]   dq0, dq1;
  logic [15:0]   mem0 [0:(1<<AW)-1];
  logic [15:0]   mem1 [0:(1<<AW)-1];
  logic [31:0]   ref_mem [int];
  int            req_cycle [2];
  int            cur_word [2];
  int            cycle = 0;
  int            errors = 0;
  int            checks = 0;
  exp_t          sb [$];

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural async SRAMs; the bench only drives DQ during its own read ops.
  assign dq0 = sram_oe[0] ? mem0[sram_addr[0]] : 16'hzzzz;
  assign dq1 = sram_oe[1] ? mem1[sram_addr[1]] : 16'hzzzz;
  always @(posedge clk) begin
    if (!we_n[0]) mem0[sram_addr[0]] = dq0;
    if (!we_n[1]) mem1[sram_addr[1]] = dq1;
  end

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(1), .SRAM_AW(AW)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]),
    .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
    .ready(ready[0]), .SRAM_DQ(dq0), .SRAM_ADDR(sram_addr[0]), .SRAM_WE_N(we_n[0])
  );

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(3), .SRAM_AW(AW)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]),
    .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
    .ready(ready[1]), .SRAM_DQ(dq1), .SRAM_ADDR(sram_addr[1]), .SRAM_WE_N(we_n[1])
  );

  function automatic int wc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return int'(off >> 2) & WMASK;
  endfunction

  function automatic logic [31:0] ref_rd(input int key);
    return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: per-cycle bus expectations from elapsed time, response from scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy[i]) begin
        int   k;
        logic exp_we;
        exp_t e;
        k = cycle - req_cycle[i];
        if (k >= 1 && k <= 2 * wc(i)) begin
          chk($sformatf("sram_addr%0d", i), 32'(sram_addr[i]),
              32'(2 * cur_word[i] + ((k > wc(i)) ? 1 : 0)));
          exp_we = cur_wr[i] ? ((wc(i) >= 2) && (((k - 1) % wc(i)) == wc(i) - 1)) : 1'b1;
          chk($sformatf("we_n%0d", i), 32'(we_n[i]), 32'(exp_we));
        end
        if (ready[i]) begin
          if (sb.size() == 0) begin
            chk($sformatf("unexpected_ready%0d", i), 32'(1), 32'(0));
          end else begin
            e = sb.pop_front();
            chk($sformatf("sb_idx%0d", i), 32'(i), 32'(e.idx));
            chk($sformatf("read_data%0d", i), read_data[i], e.rdata);
            chk($sformatf("latency%0d", i), 32'(k), 32'(e.lat));
          end
          busy[i] = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int i, input bit w, input bit r,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   key;
    key = (i << 20) | word_of(a);
    @(posedge clk); #1;
    wr_en[i] = w; rd_en[i] = r; address[i] = a; write_data[i] = d;
    cur_word[i] = word_of(a); cur_wr[i] = w; req_cycle[i] = cycle;
    sram_oe[i] = r & ~w;
    busy[i] = 1'b1;
    if (w) ref_mem[key] = d;
    else   last_rd[i] = ref_rd(key);
    e.idx = i; e.rdata = last_rd[i]; e.lat = 1 + 2 * wc(i);
    sb.push_back(e);
    for (int n = 0; n < 40 && busy[i]; n++) begin
      @(posedge clk); #2;
      if (n == 0) begin
        address[i] = $urandom; write_data[i] = $urandom;
      end
    end
    if (busy[i]) begin
      chk($sformatf("timeout%0d", i), 32'(1), 32'(0));
      busy[i] = 1'b0;
      void'(sb.pop_front());
    end
    wr_en[i] = 1'b0; rd_en[i] = 1'b0; sram_oe[i] = 1'b0;
  endtask

  task automatic idle_hold(input int i, input int n);
    repeat (n) begin
      @(negedge clk);
      chk($sformatf("hold_rd%0d", i), read_data[i], last_rd[i]);
      chk($sformatf("idle_ready%0d", i), 32'(ready[i]), 32'(1));
      chk($sformatf("idle_we_n%0d", i), 32'(we_n[i]), 32'(1));
    end
  endtask

  initial begin
    logic [31:0] a;
    int          op;
    for (int j = 0; j < (1 << AW); j++) begin
      mem0[j] = 16'h0; mem1[j] = 16'h0;
    end
    wr_en = '0; rd_en = '0; sram_oe = '0; busy = '0; cur_wr = '0;
    for (int i = 0; i < 2; i++) begin
      address[i] = '0; write_data[i] = '0; last_rd[i] = '0;
      req_cycle[i] = 0; cur_word[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'(1));
      chk($sformatf("rst_we_n%0d", i), 32'(we_n[i]), 32'(1));
      chk($sformatf("rst_rd%0d", i), read_data[i], 32'h0);
      chk($sformatf("rst_addr%0d", i), 32'(sram_addr[i]), 32'h0);
    end

    issue(0, 1, 0, 32'd1024, 32'hDEADBEEF);
    chk("mem_w0", 32'(mem0[0]), 32'h0000BEEF);
    chk("mem_w1", 32'(mem0[1]), 32'h0000DEAD);
    issue(0, 0, 1, 32'd1024, 32'h0);
    idle_hold(0, 3);
    issue(0, 1, 1, 32'd1028, 32'h12345678);
    chk("mem_w2", 32'(mem0[2]), 32'h00005678);
    chk("mem_w3", 32'(mem0[3]), 32'h00001234);
    idle_hold(0, 1);
    issue(1, 0, 1, 32'd1044, 32'h0);

    // Abort a write in its high phase: only the low half reaches the SRAM.
    @(posedge clk); #1;
    wr_en[0] = 1'b1; address[0] = 32'd1024; write_data[0] = 32'hAAAA5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    wr_en[0] = 1'b0; #1;
    chk("abort_ready", 32'(ready[0]), 32'(1));
    chk("abort_we_n", 32'(we_n[0]), 32'(1));
    chk("abort_rd", read_data[0], 32'h0);
    chk("abort_rd1", read_data[1], 32'h0);
    last_rd[0] = '0; last_rd[1] = '0;
    ref_mem[0] = {ref_rd(0) >> 16, 16'h5555};
    @(negedge clk);
    rst = 1'b0;
    issue(0, 0, 1, 32'd1024, 32'h0);

    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 25; n++) begin
        op = $urandom_range(0, 3);
        if ($urandom_range(0, 7) == 0) a = 32'(BASE - 4 * $urandom_range(1, 3));
        else                           a = 32'(BASE + 4 * $urandom_range(0, 15));
        a = a | 32'($urandom_range(0, 3));
        issue(i, op >= 2, op != 2, a, $urandom);
      end
      idle_hold(i, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
